// File: rtl/spectro_frame_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spectro_pkg
// Description : Shared types and helpers for the spectrogram frame engine:
//               shifter state encoding, word-index width and a ceil-log2
//               helper used to size the tick and bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
package spectro_pkg;

    localparam int WORD_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spectro_frame_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : spectro_frame_engine_if
// Description : Channel/tick inputs and serial-stream outputs of the frame
//               engine. The master side (comparator front end plus link
//               receiver) drives ch_in/rtc_tick; the slave side (the engine)
//               drives serial_out, frame_sync, word_idx, busy, ovf_global and
//               overrun.
// Revision    : 1.0 - initial release
// ============================================================================
interface spectro_frame_engine_if #(
    parameter int N_CH = 15
);
    logic [N_CH-1:0]                     ch_in;
    logic                                rtc_tick;
    logic                                serial_out;
    logic                                frame_sync;
    logic [spectro_pkg::WORD_IDX_W-1:0]  word_idx;
    logic                                busy;
    logic                                ovf_global;
    logic                                overrun;

    modport master (
        output ch_in, rtc_tick,
        input  serial_out, frame_sync, word_idx, busy, ovf_global, overrun
    );

    modport slave (
        input  ch_in, rtc_tick,
        output serial_out, frame_sync, word_idx, busy, ovf_global, overrun
    );
endinterface
`default_nettype wire

// File: rtl/spectro_frame_engine_edge_pulse_counter.sv
`default_nettype none
// ============================================================================
// Module      : edge_pulse_counter
// Description : One channel: 2-FF synchroniser, rising-edge detect and a
//               saturating counter with a sticky sat flag.
//               Ports: clk, reset (async, active-high), ch_in (async pulse),
//               clr (frame close), count (live count), sat_rise (one cycle
//               when the counter first reaches all-ones).
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pulse_counter #(
    parameter int CNT_W = 12
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             ch_in,
    input  wire logic             clr,
    output logic [CNT_W-1:0]      count,
    output logic                  sat_rise
);
    localparam logic [CNT_W-1:0] C_MAX    = '1;
    localparam logic [CNT_W-1:0] C_MAX_M1 = C_MAX - 1'b1;

    logic [1:0]       r_sync;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             r_sat_d;

    logic             w_edge;
    logic             w_inc;
    logic             w_hit;
    logic [CNT_W-1:0] w_base;

    assign w_edge = r_sync[1] & ~r_prev;
    // A clear wins over the old count, but an edge in the clearing cycle
    // still lands in the new frame.
    assign w_base = clr ? '0 : r_cnt;
    assign w_inc  = w_edge && (w_base != C_MAX);
    assign w_hit  = w_inc && (w_base == C_MAX_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_sat_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], ch_in};
            r_prev  <= r_sync[1];
            r_cnt   <= w_inc ? w_base + 1'b1 : w_base;
            r_sat   <= (r_sat & ~clr) | w_hit;
            r_sat_d <= r_sat & ~clr;
        end
    end

    assign count    = r_cnt;
    assign sat_rise = r_sat & ~r_sat_d;

endmodule
`default_nettype wire

// File: rtl/spectro_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : spectro_frame_engine
// Description : Pulse-count spectrogram front end. Counts channel edges per
//               frame, closes frames on tick count or channel saturation,
//               snapshots {frame_idx, counts} and streams them MSB-first while
//               live counting continues.
//               Ports: clk, reset (async, active-high), bus (slave modport:
//               ch_in, rtc_tick in; serial_out, frame_sync, word_idx, busy,
//               ovf_global, overrun out).
// Revision    : 1.0 - initial release
// ============================================================================
module spectro_frame_engine
    import spectro_pkg::*;
#(
    parameter int N_CH        = 15,
    parameter int CNT_W       = 12,
    parameter int FRAME_TICKS = 60,
    parameter int SAT_TRIGGER = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    spectro_frame_engine_if.slave  bus
);
    localparam int TICK_W = (clog2(FRAME_TICKS) < 1) ? 1 : clog2(FRAME_TICKS);
    localparam int BIT_W  = (clog2(CNT_W) < 1) ? 1 : clog2(CNT_W);
    localparam logic [TICK_W-1:0]     C_LAST_TICK = TICK_W'(FRAME_TICKS - 1);
    localparam logic [BIT_W-1:0]      C_LAST_BIT  = BIT_W'(CNT_W - 1);
    localparam logic [WORD_IDX_W-1:0] C_LAST_WORD = WORD_IDX_W'(N_CH);

    logic [CNT_W-1:0]      w_count [N_CH];
    logic [N_CH-1:0]       w_sat_rise;
    logic                  w_time_close;
    logic                  w_sat_close;
    logic                  w_close;
    logic [CNT_W-1:0]      w_cur_word;

    logic [TICK_W-1:0]     r_tick_cnt;
    logic [CNT_W-1:0]      r_frame_idx;
    logic [CNT_W-1:0]      r_shadow [N_CH+1];
    logic [BIT_W-1:0]      r_bit;
    logic [WORD_IDX_W-1:0] r_word;
    logic                  r_ovf;
    logic                  r_overrun;
    state_t                r_state;
    state_t                w_state_next;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            edge_pulse_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .ch_in    (bus.ch_in[k]),
                .clr      (w_close),
                .count    (w_count[k]),
                .sat_rise (w_sat_rise[k])
            );
        end
    endgenerate

    assign w_time_close = bus.rtc_tick && (r_tick_cnt == C_LAST_TICK);
    assign w_sat_close  = (SAT_TRIGGER != 0) && (|w_sat_rise);
    assign w_close      = w_time_close || w_sat_close;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_close) begin
            r_tick_cnt <= '0;
        end else if (bus.rtc_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Frame index and counters advance on every close; the snapshot is only
    // taken when the shifter is free, otherwise the close is reported as an
    // overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_idx <= '0;
            r_ovf       <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i <= N_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_ovf     <= w_sat_close;
            r_overrun <= w_close && (r_state != IDLE);
            if (w_close) begin
                r_frame_idx <= r_frame_idx + 1'b1;
                if (r_state == IDLE) begin
                    r_shadow[0] <= r_frame_idx;
                    for (int i = 0; i < N_CH; i++) begin
                        r_shadow[i+1] <= w_count[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit  <= '0;
            r_word <= '0;
        end else if (r_state == LOAD) begin
            r_bit  <= '0;
            r_word <= '0;
        end else if (r_state == SHIFT) begin
            if (r_bit == C_LAST_BIT) begin
                r_bit  <= '0;
                r_word <= r_word + 1'b1;
            end else begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cur_word     = '0;
        bus.busy       = (r_state != IDLE);
        bus.frame_sync = 1'b0;
        bus.word_idx   = '0;
        bus.serial_out = 1'b0;
        bus.ovf_global = r_ovf;
        bus.overrun    = r_overrun;

        for (int i = 0; i <= N_CH; i++) begin
            if (r_word == WORD_IDX_W'(i)) begin
                w_cur_word = r_shadow[i];
            end
        end

        case (r_state)
            IDLE:  if (w_close) w_state_next = LOAD;
            LOAD:  w_state_next = SHIFT;
            SHIFT: begin
                bus.frame_sync = (r_word == '0) && (r_bit == '0);
                bus.word_idx   = r_word;
                bus.serial_out = w_cur_word[C_LAST_BIT - r_bit];
                if ((r_word == C_LAST_WORD) && (r_bit == C_LAST_BIT)) begin
                    w_state_next = GAP;
                end
            end
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spectro_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spectro_frame_engine
// Description : Self-checking bench. Three engines (12-bit trigger, 4-bit
//               trigger, 4-bit hold) share one clock and reset; each has its
//               own channel/tick drivers. A per-channel pulse tally with
//               saturation clamping predicts every streamed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spectro_frame_engine;
    import spectro_pkg::*;

    localparam int N = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spectro_frame_engine_if #(.N_CH(N)) if_a ();
    spectro_frame_engine_if #(.N_CH(N)) if_b ();
    spectro_frame_engine_if #(.N_CH(N)) if_c ();

    spectro_frame_engine #(.N_CH(N), .CNT_W(12), .FRAME_TICKS(4), .SAT_TRIGGER(1)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    spectro_frame_engine #(.N_CH(N), .CNT_W(4), .FRAME_TICKS(4), .SAT_TRIGGER(1)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));
    spectro_frame_engine #(.N_CH(N), .CNT_W(4), .FRAME_TICKS(4), .SAT_TRIGGER(0)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave));

    logic [N-1:0]          ch_drv   [3];
    logic                  tick_drv [3];
    logic                  ser [3], fs [3], bsy [3], ovf [3], ovr [3];
    logic [WORD_IDX_W-1:0] widx [3];

    assign if_a.ch_in = ch_drv[0];  assign if_a.rtc_tick = tick_drv[0];
    assign if_b.ch_in = ch_drv[1];  assign if_b.rtc_tick = tick_drv[1];
    assign if_c.ch_in = ch_drv[2];  assign if_c.rtc_tick = tick_drv[2];

    assign ser[0] = if_a.serial_out; assign fs[0] = if_a.frame_sync; assign bsy[0] = if_a.busy;
    assign ovf[0] = if_a.ovf_global; assign ovr[0] = if_a.overrun;   assign widx[0] = if_a.word_idx;
    assign ser[1] = if_b.serial_out; assign fs[1] = if_b.frame_sync; assign bsy[1] = if_b.busy;
    assign ovf[1] = if_b.ovf_global; assign ovr[1] = if_b.overrun;   assign widx[1] = if_b.word_idx;
    assign ser[2] = if_c.serial_out; assign fs[2] = if_c.frame_sync; assign bsy[2] = if_c.busy;
    assign ovf[2] = if_c.ovf_global; assign ovr[2] = if_c.overrun;   assign widx[2] = if_c.word_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int ovf_cnt [3] = '{0, 0, 0};
    int ovr_cnt [3] = '{0, 0, 0};

    // Reference model: pulses sent in the open frame and the frame index.
    int m_cnt [3][N];
    int m_idx [3];
    int exp_words [16];
    int cap_words [16];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ovf[d]) ovf_cnt[d]++;
            if (ovr[d]) ovr_cnt[d]++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            m_idx[d] = 0;
            for (int k = 0; k < N; k++) m_cnt[d][k] = 0;
        end
    endtask

    task automatic pulse_mask(input int d, input logic [N-1:0] mask);
        @(negedge clk);
        ch_drv[d] = mask;
        for (int k = 0; k < N; k++) if (mask[k]) m_cnt[d][k]++;
        repeat (2) @(negedge clk);
        ch_drv[d] = '0;
        @(negedge clk);
    endtask

    task automatic tick(input int d);
        @(negedge clk);
        tick_drv[d] = 1'b1;
        @(negedge clk);
        tick_drv[d] = 1'b0;
    endtask

    task automatic ticks_random(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            tick(d);
        end
    endtask

    // Frame content as seen at the close: index, then clamped pulse counts.
    task automatic expect_snapshot(input int d, input int w);
        int maxv;
        maxv = (1 << w) - 1;
        exp_words[0] = m_idx[d] & maxv;
        for (int k = 0; k < N; k++) begin
            exp_words[k+1] = (m_cnt[d][k] > maxv) ? maxv : m_cnt[d][k];
            m_cnt[d][k] = 0;
        end
        m_idx[d]++;
    endtask

    task automatic drop_close(input int d);
        for (int k = 0; k < N; k++) m_cnt[d][k] = 0;
        m_idx[d]++;
    endtask

    task automatic capture(input int d, input int w, input string name);
        bit seen;
        int nsync;
        int bad_idx;
        seen = 1'b0;
        nsync = 0;
        bad_idx = 0;
        for (int k = 0; k < 16; k++) cap_words[k] = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (fs[d]) seen = 1'b1;
        end
        check_value({name, "_sync_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            for (int b = 0; b < 16 * w; b++) begin
                if (b != 0) @(negedge clk);
                if (fs[d]) nsync++;
                if (int'(widx[d]) != b / w) bad_idx++;
                if (!bsy[d]) bad_idx++;
                cap_words[b / w] = (cap_words[b / w] << 1) | int'(ser[d]);
            end
            check_value({name, "_sync_count"}, 32'(nsync), 32'd1);
            check_value({name, "_word_idx_busy"}, 32'(bad_idx), 32'd0);
            @(negedge clk);
            check_value({name, "_gap"}, {30'd0, bsy[d], ser[d]}, 32'b10);
            @(negedge clk);
            check_value({name, "_idle_busy"}, 32'(bsy[d]), 32'd0);
            for (int k = 0; k < 16; k++) begin
                check_value($sformatf("%s_word%0d", name, k), 32'(cap_words[k]), 32'(exp_words[k]));
            end
        end
    endtask

    task automatic random_pulses(input int d, input int max_slots);
        int n;
        n = $urandom_range(max_slots, 0);
        for (int i = 0; i < n; i++) pulse_mask(d, N'($urandom));
    endtask

    task automatic idle_outputs(input int d, input string name);
        check_value(name, {26'd0, ser[d], fs[d], bsy[d], ovf[d], ovr[d], |widx[d]}, 32'd0);
    endtask

    initial begin
        int o0, r0;
        bit seen;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            ch_drv[d] = '0;
            tick_drv[d] = 1'b0;
        end
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        idle_outputs(0, "reset_a");
        idle_outputs(1, "reset_b");
        idle_outputs(2, "reset_c");

        // Basic frame: 5 pulses on channel 1, 3 on channel 15.
        for (int i = 0; i < 5; i++) pulse_mask(0, (i < 3) ? 15'h4001 : 15'h0001);
        ticks_random(0, 4);
        expect_snapshot(0, 12);
        check_value("basic_exp_ch1", 32'(exp_words[1]), 32'd5);
        capture(0, 12, "basic");

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            random_pulses(0, 10);
            ticks_random(0, 4);
            expect_snapshot(0, 12);
            capture(0, 12, $sformatf("rand%0d", f));
        end

        // Saturation close on a 4-bit engine; the 16th pulse opens the next frame.
        for (int i = 0; i < 14; i++) pulse_mask(1, 15'h0004);
        o0 = ovf_cnt[1];
        pulse_mask(1, 15'h0004);
        expect_snapshot(1, 4);
        fork
            capture(1, 4, "sat");
            begin
                repeat (4) @(negedge clk);
                pulse_mask(1, 15'h0004);
            end
        join
        check_value("sat_ovf_pulse", 32'(ovf_cnt[1] - o0), 32'd1);
        ticks_random(1, 4);
        expect_snapshot(1, 4);
        capture(1, 4, "sat_next");
        check_value("sat_no_extra_ovf", 32'(ovf_cnt[1] - o0), 32'd1);

        // Hold mode: saturate without closing, then close by time.
        o0 = ovf_cnt[2];
        for (int i = 0; i < 20; i++) pulse_mask(2, 15'h0004);
        check_value("hold_not_busy", 32'(bsy[2]), 32'd0);
        ticks_random(2, 4);
        expect_snapshot(2, 4);
        capture(2, 4, "hold");
        check_value("hold_no_ovf", 32'(ovf_cnt[2] - o0), 32'd0);

        // Boundary: edge detected in the closing cycle belongs to the new frame.
        random_pulses(0, 6);
        ticks_random(0, 3);
        @(negedge clk);
        ch_drv[0] = 15'h0100;
        @(negedge clk);
        @(negedge clk);
        tick_drv[0] = 1'b1;
        ch_drv[0] = '0;
        expect_snapshot(0, 12);
        m_cnt[0][8] = 1;
        @(negedge clk);
        tick_drv[0] = 1'b0;
        capture(0, 12, "boundary");
        ticks_random(0, 4);
        expect_snapshot(0, 12);
        check_value("boundary_exp_ch9", 32'(exp_words[9]), 32'd1);
        capture(0, 12, "boundary_next");

        // Overrun: a full frame of ticks lands while the shifter is busy.
        r0 = ovr_cnt[0];
        random_pulses(0, 6);
        ticks_random(0, 4);
        expect_snapshot(0, 12);
        fork
            capture(0, 12, "ovr_frame");
            begin
                repeat (20) @(negedge clk);
                for (int i = 0; i < 4; i++) tick(0);
            end
        join
        drop_close(0);
        check_value("overrun_pulse", 32'(ovr_cnt[0] - r0), 32'd1);
        random_pulses(0, 6);
        ticks_random(0, 4);
        expect_snapshot(0, 12);
        capture(0, 12, "after_ovr");

        // Async reset in the middle of a shift.
        random_pulses(0, 4);
        ticks_random(0, 4);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (fs[0]) seen = 1'b1;
        end
        check_value("rst_shift_started", 32'(seen), 32'd1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check_value("rst_async_outputs", {29'd0, ser[0], fs[0], bsy[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        random_pulses(0, 6);
        ticks_random(0, 4);
        expect_snapshot(0, 12);
        capture(0, 12, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
